// File: rtl/serial_pkg.sv
// Shared definitions for the parity-protected serial link (receiver and transmitter).
package serial_pkg;

  // Receiver FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Frame line levels
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Parity sense: value the XOR of data and parity bit must equal
  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_sense_e;

  // Per-frame error flags delivered with each data word
  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_flags_t;

  // Seed for the running XOR so that a nonzero result means a parity mismatch
  function automatic logic parity_seed(input parity_sense_e sense);
    return (sense == PAR_ODD);
  endfunction

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle level.
module rx_sync2
  import serial_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= IDLE_LVL;
      q    <= IDLE_LVL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Oversampling receiver for idle-high start/data/parity/stop frames with parity and framing checks.
module serial_parity_rx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned OVS        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  input  logic              tick,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned TICK_W = $clog2(OVS);
  localparam int unsigned BIT_W  = $clog2(DATA_W);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVS / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  localparam parity_sense_e SENSE    = PARITY_ODD ? PAR_ODD : PAR_EVEN;
  localparam logic          PAR_SEED = parity_seed(SENSE);

  logic rx_s;

  rx_state_e         state,    state_n;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [BIT_W-1:0]  bit_cnt,  bit_cnt_n;
  logic [DATA_W-1:0] shift,    shift_n;
  logic              par,      par_n;
  logic              perr,     perr_n;
  logic              brk,      brk_n;
  logic              busy_n;
  logic [DATA_W-1:0] data_out_n;
  logic              data_valid_n;
  rx_flags_t         flags,    flags_n;

  rx_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  // State, counters, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      perr       <= 1'b0;
      brk        <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      flags      <= '0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par        <= par_n;
      perr       <= perr_n;
      brk        <= brk_n;
      busy       <= busy_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      flags      <= flags_n;
    end
  end

  // Next-state and datapath logic; everything advances only on tick
  always_comb begin
    state_n      = state;
    tick_cnt_n   = tick_cnt;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    par_n        = par;
    perr_n       = perr;
    brk_n        = brk;
    busy_n       = busy;
    data_out_n   = data_out;
    flags_n      = flags;
    data_valid_n = 1'b0;

    if (tick) begin
      // Break is released as soon as the line is seen back at idle
      if (rx_s == IDLE_LVL) begin
        brk_n = 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!brk && rx_s == START_BIT) begin
            state_n    = ST_START;
            tick_cnt_n = '0;
            busy_n     = 1'b1;
          end
        end

        ST_START: begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt_n = '0;
            if (rx_s == START_BIT) begin
              state_n   = ST_DATA;
              bit_cnt_n = '0;
              par_n     = PAR_SEED;
            end else begin
              // Start glitch: drop back without touching the output flags
              state_n = ST_IDLE;
              busy_n  = 1'b0;
            end
          end else begin
            tick_cnt_n = tick_cnt + TICK_W'(1);
          end
        end

        ST_DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            shift_n    = {rx_s, shift[DATA_W-1:1]};
            par_n      = par ^ rx_s;
            if (bit_cnt == BIT_LAST) begin
              state_n   = ST_PARITY;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_cnt_n = tick_cnt + TICK_W'(1);
          end
        end

        ST_PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            perr_n     = par ^ rx_s;
            state_n    = ST_STOP;
          end else begin
            tick_cnt_n = tick_cnt + TICK_W'(1);
          end
        end

        ST_STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n         = '0;
            state_n            = ST_IDLE;
            busy_n             = 1'b0;
            data_out_n         = shift;
            flags_n.parity_err = perr;
            flags_n.frame_err  = (rx_s != STOP_BIT);
            data_valid_n       = 1'b1;
            if (rx_s != STOP_BIT) begin
              brk_n = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + TICK_W'(1);
          end
        end

        default: begin
          state_n    = ST_IDLE;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
          busy_n     = 1'b0;
        end
      endcase
    end
  end

  assign parity_err = flags.parity_err;
  assign frame_err  = flags.frame_err;

endmodule
